// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (CPU and print/debug) and the shared
//   single-port memory port served by dmem_arbiter.
//   cpu_* / dbg_* : req, we, addr, wdata in; gnt, ready, rdata out of arbiter
//   mem_*         : en, we, addr, wdata out of arbiter; rdata into arbiter
//   slave  : arbiter view
//   master : environment view (requesters + memory)
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_ready;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_ready, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_ready, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_ready, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_ready, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter sharing one single-port data memory between the CPU
//   and a print/debug requester. One transaction at a time:
//   IDLE -> ISSUE (mem_en pulse) -> WAIT (MEM_LAT cycles) -> RESP (ready).
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : dmem_arbiter_if.slave (requester and memory signals)
//     busy  : high whenever the FSM is not in IDLE
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d;     // granted requester: 0 = CPU, 1 = dbg
    logic              last_q, last_d;   // winner of the most recent tie
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;          // dbg, so the CPU wins the first tie
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    state_d = ISSUE;
                    // The pointer only moves on a tie; a lone requester
                    // leaves the tie history untouched.
                    if (bus.cpu_req && bus.dbg_req) begin
                        sel_d  = ~last_q;
                        last_d = ~last_q;
                    end else begin
                        sel_d  = bus.dbg_req;
                    end
                    if (sel_d) begin
                        we_d    = bus.dbg_we;
                        addr_d  = bus.dbg_addr;
                        wdata_d = bus.dbg_wdata;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (sel_q) dbg_rdata_d = bus.mem_rdata;
                        else       cpu_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state so reset clears them immediately.
    always_comb begin
        busy          = (state_q != IDLE);
        bus.cpu_gnt   = busy && !sel_q;
        bus.dbg_gnt   = busy &&  sel_q;
        bus.cpu_ready = (state_q == RESP) && !sel_q;
        bus.dbg_ready = (state_q == RESP) &&  sel_q;
        bus.cpu_rdata = cpu_rdata_q;
        bus.dbg_rdata = dbg_rdata_q;
        bus.mem_en    = (state_q == ISSUE);
        bus.mem_we    = (state_q == ISSUE) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int LA = 1;   // latency of instance A
    localparam int LB = 3;   // latency of instance B

    typedef struct {
        logic        who;    // 0 = CPU, 1 = dbg
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] mema [0:1023];
    logic [31:0] memb [0:1023];
    logic [31:0] pa_data [0:3];
    logic        pa_vld  [0:3];
    logic [31:0] pb_data [0:3];
    logic        pb_vld  [0:3];

    logic        pl_en = 1'b0;
    int          pl_sel = 0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(10)) ifb ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(LA)) u_dut_a (
        .clock(clk), .reset(rst_n), .bus(ifa), .busy(busy_a));
    dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(LB)) u_dut_b (
        .clock(clk), .reset(rst_n), .bus(ifb), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data valid only in the cycle MEM_LAT after mem_en.
    always @(posedge clk) begin
        if (pl_en && pl_sel == 0) mema[pl_addr] <= pl_data;
        if (pl_en && pl_sel == 1) memb[pl_addr] <= pl_data;
        if (ifa.mem_en && ifa.mem_we) mema[ifa.mem_addr] <= ifa.mem_wdata;
        if (ifb.mem_en && ifb.mem_we) memb[ifb.mem_addr] <= ifb.mem_wdata;
        pa_vld[0]  <= ifa.mem_en && !ifa.mem_we;
        pa_data[0] <= mema[ifa.mem_addr];
        pb_vld[0]  <= ifb.mem_en && !ifb.mem_we;
        pb_data[0] <= memb[ifb.mem_addr];
        for (int i = 1; i < 4; i++) begin
            pa_vld[i]  <= pa_vld[i-1];
            pa_data[i] <= pa_data[i-1];
            pb_vld[i]  <= pb_vld[i-1];
            pb_data[i] <= pb_data[i-1];
        end
    end

    assign ifa.mem_rdata = pa_vld[LA-1] ? pa_data[LA-1] : 32'hBAD0BAD0;
    assign ifb.mem_rdata = pb_vld[LB-1] ? pb_data[LB-1] : 32'hBAD0BAD0;

    // Scoreboard monitor
    task automatic mon(input int d, input logic who, input logic [31:0] rd,
                       input logic own_g, input logic oth_g);
        exp_t e;
        checks++;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_ready dut%0d: got ready who=%0d at cyc=%0d, required no ready",
                     d, who, cyc);
        end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            if (e.who !== who || e.rdata !== rd || e.cyc != cyc || own_g !== 1'b1 || oth_g !== 1'b0) begin
                errors++;
                $display("FAIL ready dut%0d: got who=%0d rdata=%h cyc=%0d gnt(own,other)=%b%b, required who=%0d rdata=%h cyc=%0d gnt=10",
                         d, who, rd, cyc, own_g, oth_g, e.who, e.rdata, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ifa.cpu_ready) mon(0, 1'b0, ifa.cpu_rdata, ifa.cpu_gnt, ifa.dbg_gnt);
        if (ifa.dbg_ready) mon(0, 1'b1, ifa.dbg_rdata, ifa.dbg_gnt, ifa.cpu_gnt);
        if (ifb.cpu_ready) mon(1, 1'b0, ifb.cpu_rdata, ifb.cpu_gnt, ifb.dbg_gnt);
        if (ifb.dbg_ready) mon(1, 1'b1, ifb.dbg_rdata, ifb.dbg_gnt, ifb.cpu_gnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic who, input logic [31:0] rd, input int c);
        exp_t e;
        e.who = who; e.rdata = rd; e.cyc = c;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic preload(input int which, input int addr, input logic [31:0] d);
        pl_sel  = which;
        pl_addr = addr[9:0];
        pl_data = d;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int n = 0; n < 40; n++) begin
            if ((d == 0 && !busy_a) || (d == 1 && !busy_b)) break;
            step();
        end
        chk($sformatf("idle_timeout_dut%0d", d), {31'b0, (d == 0) ? busy_a : busy_b}, 32'd0);
    endtask

    task automatic chk_quiet_a(input string tag);
        chk({tag, "_ctl"}, {25'b0, busy_a, ifa.cpu_gnt, ifa.dbg_gnt, ifa.cpu_ready,
                            ifa.dbg_ready, ifa.mem_en, ifa.mem_we}, 32'd0);
        chk({tag, "_mem_addr"},  {22'b0, ifa.mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, ifa.mem_wdata, 32'd0);
        chk({tag, "_cpu_rdata"}, ifa.cpu_rdata, 32'd0);
        chk({tag, "_dbg_rdata"}, ifa.dbg_rdata, 32'd0);
    endtask

    initial begin
        int k;
        ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
        ifa.dbg_req = 0; ifa.dbg_we = 0; ifa.dbg_addr = '0; ifa.dbg_wdata = '0;
        ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
        ifb.dbg_req = 0; ifb.dbg_we = 0; ifb.dbg_addr = '0; ifb.dbg_wdata = '0;

        // Reset state and memory preload
        preload(0, 5, 32'h12345678);
        preload(0, 1, 32'h11111111);
        preload(0, 2, 32'h22222222);
        preload(1, 3, 32'hCAFEF00D);
        preload(1, 9, 32'h99999999);
        chk_quiet_a("reset_a");
        chk("reset_b_ctl", {25'b0, busy_b, ifb.cpu_gnt, ifb.dbg_gnt, ifb.cpu_ready,
                            ifb.dbg_ready, ifb.mem_en, ifb.mem_we}, 32'd0);
        step();
        rst_n = 1'b1;

        // Idle: no requests for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", {29'b0, busy_a, ifa.mem_en, ifa.cpu_gnt | ifa.dbg_gnt}, 32'd0);
        end

        // CPU read of word 5 (A, MEM_LAT=1)
        step();
        k = cyc;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 10'd5;
        push(0, 1'b0, 32'h12345678, k + 3);
        step();
        chk("rd_issue_ctl", {27'b0, ifa.mem_en, ifa.mem_we, ifa.cpu_gnt, ifa.dbg_gnt, busy_a}, 32'b10101);
        chk("rd_issue_addr", {22'b0, ifa.mem_addr}, 32'd5);
        ifa.cpu_req = 0;
        step();
        chk("rd_wait_ctl", {29'b0, ifa.mem_en, ifa.cpu_gnt, busy_a}, 32'b011);
        wait_idle(0);

        // dbg writes 0xDEADBEEF to 7, then CPU reads 7
        step();
        k = cyc;
        ifa.dbg_req = 1; ifa.dbg_we = 1; ifa.dbg_addr = 10'd7; ifa.dbg_wdata = 32'hDEADBEEF;
        push(0, 1'b1, 32'h0, k + 3);
        step();
        chk("wr_issue_ctl", {28'b0, ifa.mem_en, ifa.mem_we, ifa.cpu_gnt, ifa.dbg_gnt}, 32'b1101);
        ifa.dbg_req = 0;
        wait_idle(0);
        chk("wr_mem7", mema[7], 32'hDEADBEEF);
        step();
        k = cyc;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 10'd7;
        push(0, 1'b0, 32'hDEADBEEF, k + 3);
        step();
        ifa.cpu_req = 0;
        wait_idle(0);
        chk("dbg_rdata_kept", ifa.dbg_rdata, 32'h0);

        // Persistent tie out of reset: CPU, dbg, CPU, dbg
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        k = cyc;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 10'd1;
        ifa.dbg_req = 1; ifa.dbg_we = 0; ifa.dbg_addr = 10'd2;
        push(0, 1'b0, 32'h11111111, k + 3);
        push(0, 1'b1, 32'h22222222, k + 7);
        push(0, 1'b0, 32'h11111111, k + 11);
        push(0, 1'b1, 32'h22222222, k + 15);
        while (cyc < k + 15) step();
        ifa.cpu_req = 0; ifa.dbg_req = 0;
        wait_idle(0);
        step();
        chk("tie_no_fifth", {31'b0, busy_a}, 32'd0);

        // Reset during WAIT aborts without ready
        step();
        k = cyc;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 10'd5;
        step();
        ifa.cpu_req = 0;
        step();
        chk("rst_pre_busy", {31'b0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet_a("rst_wait");
        step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("rst_after_busy", {31'b0, busy_a}, 32'd0);

        // Dropped request with changed inputs (B, MEM_LAT=3)
        step();
        k = cyc;
        ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 10'd3;
        push(1, 1'b0, 32'hCAFEF00D, k + 5);
        step();
        chk("drop_issue_ctl", {30'b0, ifb.mem_en, ifb.mem_we}, 32'b10);
        chk("drop_issue_addr", {22'b0, ifb.mem_addr}, 32'd3);
        ifb.cpu_req = 0; ifb.cpu_we = 1; ifb.cpu_addr = 10'd9; ifb.cpu_wdata = 32'h55555555;
        step();
        chk("drop_wait_ctl", {29'b0, ifb.mem_en, ifb.cpu_gnt, busy_b}, 32'b011);
        wait_idle(1);
        chk("drop_mem9", memb[9], 32'h99999999);

        // Request arriving while busy is served at the next IDLE
        step();
        k = cyc;
        ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 10'd3;
        push(1, 1'b0, 32'hCAFEF00D, k + 5);
        push(1, 1'b1, 32'h0, k + 11);
        step();
        ifb.cpu_req = 0;
        ifb.dbg_req = 1; ifb.dbg_we = 1; ifb.dbg_addr = 10'd4; ifb.dbg_wdata = 32'h44444444;
        step();
        step();
        chk("busy_gnt_hold", {30'b0, ifb.cpu_gnt, ifb.dbg_gnt}, 32'b10);
        while (cyc < k + 7) step();
        chk("late_gnt", {30'b0, ifb.cpu_gnt, ifb.dbg_gnt}, 32'b01);
        ifb.dbg_req = 0;
        wait_idle(1);
        chk("late_mem4", memb[4], 32'h44444444);

        repeat (3) step();
        chk("scoreboard_a_empty", qa.size(), 32'd0);
        chk("scoreboard_b_empty", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
